// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares the single-port data memory between the core load/store port and a
// host/loader port. A winner is picked in IDLE and granted in the same cycle.
// Its request is captured and the memory strobe is held for MEM_LATENCY
// cycles. A one-cycle done pulse then goes back to that requester.
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_LATENCY   = 1,
    parameter int HOST_PRIORITY = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_req_i,
    input  logic                  core_we_i,
    input  logic [ADDR_WIDTH-1:0] core_addr_i,
    input  logic [DATA_WIDTH-1:0] core_wdata_i,
    output logic                  core_gnt_o,
    output logic                  core_done_o,
    output logic [DATA_WIDTH-1:0] core_rdata_o,
    input  logic                  host_req_i,
    input  logic                  host_we_i,
    input  logic [ADDR_WIDTH-1:0] host_addr_i,
    input  logic [DATA_WIDTH-1:0] host_wdata_i,
    output logic                  host_gnt_o,
    output logic                  host_done_o,
    output logic [DATA_WIDTH-1:0] host_rdata_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  busy_o,
    output logic                  owner_o
);

    // A zero-cycle access has no meaning; refuse to elaborate it.
    if (MEM_LATENCY < 1) begin : g_latency_check
        $error("dmem_port_arbiter: MEM_LATENCY must be >= 1");
    end

    localparam int               CNT_W         = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD      = CNT_W'(MEM_LATENCY - 1);
    localparam logic             HOST_WINS_TIE = (HOST_PRIORITY != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    owner_q, owner_d;        // 0 = core, 1 = host
    logic                    last_owner_q, last_owner_d;
    logic [DATA_WIDTH-1:0]   core_rdata_q, core_rdata_d;
    logic [DATA_WIDTH-1:0]   host_rdata_q, host_rdata_d;

    logic                    any_req;
    logic                    pick_host;

    // Host wins when it is alone, or on a tie when it has fixed priority or
    // the core was the previous owner (round-robin).
    always_comb begin
        any_req   = core_req_i | host_req_i;
        pick_host = host_req_i & (~core_req_i | HOST_WINS_TIE | ~last_owner_q);
    end

    // Next-state, capture and grant logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        core_rdata_d = core_rdata_q;
        host_rdata_d = host_rdata_q;
        core_gnt_o   = 1'b0;
        host_gnt_o   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    core_gnt_o = ~pick_host;
                    host_gnt_o = pick_host;
                    owner_d    = pick_host;
                    we_d       = pick_host ? host_we_i    : core_we_i;
                    addr_d     = pick_host ? host_addr_i  : core_addr_i;
                    wdata_d    = pick_host ? host_wdata_i : core_wdata_i;
                    cnt_d      = CNT_LOAD;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (owner_q) begin
                            host_rdata_d = mem_rdata_i;
                        end else begin
                            core_rdata_d = mem_rdata_i;
                        end
                    end
                    last_owner_d = owner_q;
                    state_d      = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // No grant may escape while the block is held in reset.
        if (reset) begin
            core_gnt_o = 1'b0;
            host_gnt_o = 1'b0;
        end
    end

    // State and captured-request registers; last_owner starts at host so the
    // core wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            core_rdata_q <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            core_rdata_q <= core_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    // Strobes only in ACCESS; address/data simply follow the capture registers.
    assign mem_read_o   = (state_q == ST_ACCESS) & ~we_q;
    assign mem_write_o  = (state_q == ST_ACCESS) &  we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign core_done_o  = (state_q == ST_DONE) & ~owner_q;
    assign host_done_o  = (state_q == ST_DONE) &  owner_q;
    assign core_rdata_o = core_rdata_q;
    assign host_rdata_o = host_rdata_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign owner_o      = owner_q;

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Arbitrates the single-port data memory between two requesters: the core load/store port and a host/loader port (debug or program-load).
- Captures the winning request and drives the memory strobes for a fixed number of cycles.
- Returns read data and a one-cycle completion pulse to the requester that won.
- Sits between the core's ALU-address/read-data-2 path and the Data_Memory instance. The core stalls on its own request until the completion pulse arrives.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- DATA_WIDTH, 32, width of all data buses.
- MEM_LATENCY, 1, number of cycles the memory strobe is held per access. Must be >= 1; a value of 0 is a compile-time error.
- HOST_PRIORITY, 0, tie-break mode. 0 = round-robin; 1 = host always wins a tie.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- core_req_i  in  1  core request
- core_we_i  in  1  core request is a write (1) or read (0)
- core_addr_i  in  ADDR_WIDTH  core address
- core_wdata_i  in  DATA_WIDTH  core write data
- core_gnt_o  out  1  core request accepted this cycle
- core_done_o  out  1  core transaction complete (1-cycle pulse)
- core_rdata_o  out  DATA_WIDTH  core read data
- host_req_i / host_we_i / host_addr_i / host_wdata_i  in  1/1/ADDR_WIDTH/DATA_WIDTH  host request, same meaning as the core signals
- host_gnt_o / host_done_o / host_rdata_o  out  1/1/DATA_WIDTH  host grant, completion pulse, read data
- mem_read_o  out  1  memory read strobe
- mem_write_o  out  1  memory write strobe
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_rdata_i  in  DATA_WIDTH  memory read data, combinational from mem_addr_o
- busy_o  out  1  arbiter is not in IDLE
- owner_o  out  1  owner of the current or last transaction (0 = core, 1 = host)

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: state IDLE, all gnt/done/mem strobes 0, mem_addr_o 0, mem_wdata_o 0, both rdata 0, owner_o 0, last_owner 1 (so the core wins the first tie).
- While reset is asserted, both gnt outputs are forced to 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, arbitration:
  - Requests are sampled only in this state.
  - One requester active: that requester wins.
  - Both active, HOST_PRIORITY=0: winner = ~last_owner.
  - Both active, HOST_PRIORITY=1: the host wins.
- IDLE, grant and capture:
  - The winner's gnt_o is asserted combinationally in the same cycle.
  - On that clock edge the arbiter captures we, addr, wdata and owner, loads cnt = MEM_LATENCY-1, and goes to ACCESS.
  - No request: remain in IDLE.
- ACCESS:
  - mem_read_o = ~we_q and mem_write_o = we_q.
  - mem_addr_o and mem_wdata_o come from the captured registers and stay stable for all MEM_LATENCY cycles. Holding the write strobe for several cycles rewrites the same word, which is harmless.
  - cnt decrements each cycle.
  - When cnt==0, on the clock edge: a read loads mem_rdata_i into the owner's rdata register; last_owner takes the owner; state goes to DONE.
- DONE:
  - The owner's done_o is high for exactly this cycle; mem strobes are 0.
  - Next state is IDLE unconditionally.
- rdata_o holds its value until that requester's next completed read. Writes never change rdata_o.
- Latency: gnt to done = MEM_LATENCY+1 cycles. Throughput = one transaction per MEM_LATENCY+2 cycles.
- Request changes during ACCESS/DONE: changes on req/we/addr/wdata are ignored; captured values are used.
- Re-requesting: a requester still asserting req in the IDLE cycle after its done is treated as a new request and re-arbitrated normally.
- Idle strobes: mem strobes are never asserted in IDLE or DONE. mem_addr_o and mem_wdata_o hold their last captured values.
- busy_o = (state != IDLE).
- Reset mid-transaction: the FSM returns to IDLE immediately and asynchronously; strobes drop the same instant; no done pulse is issued; rdata and arbitration history are reset.
- Never both gnt in the same cycle; never both done in the same cycle.

Test Plan:
1. Core-only read, MEM_LATENCY=1, mem word[0x10]=0xDEADBEEF; core_req with addr 0x10 in cycle 0 -> core_gnt_o=1 in cycle 0; mem_read_o=1 with mem_addr_o=0x10 in cycle 1; core_done_o=1 and core_rdata_o=0xDEADBEEF in cycle 2; busy_o=0 in cycle 3.
2. Simultaneous requests, round-robin, core reads 0x4 and host writes 0xA5A5A5A5 to 0x8, both holding req -> core granted first (last_owner=1 at reset); host granted in the following IDLE cycle; mem_write_o=1 with addr 0x8 for exactly MEM_LATENCY cycles; host_rdata_o unchanged.
3. HOST_PRIORITY=1, both requesting continuously for 3 transactions -> host granted every time, core_gnt_o never asserted; then the host drops req -> core granted in the next IDLE.
4. MEM_LATENCY=4, host read -> mem_read_o high for 4 consecutive cycles with a stable address; host_done_o exactly 5 cycles after host_gnt_o; core_addr_i toggled during ACCESS has no effect on mem_addr_o.
5. Reset asserted in the 2nd ACCESS cycle of a core write (MEM_LATENCY=3) -> mem_write_o falls without waiting for a clock edge; no core_done_o; after release, busy_o=0 and a core/host tie grants the core.
6. Back-to-back core reads of 0x0 (value 0x11) then 0x4 (value 0x22) -> core_rdata_o reads 0x11 after the first done and stays 0x11 until the second done, then reads 0x22; host_rdata_o stays 0.
